glb_port_arbiter: RTL and testbench

//   Shares the single GLB port between two requesters: host/DRAM loader (req 0) and the
//   PE-array pass controller (req 1). Replaces the static op_config[0] mux at top level.

---
 rtl/glb_arb_pkg.sv | 23 ++
 rtl/glb_rsp_router.sv | 39 +++
 rtl/glb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_glb_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_arb_pkg.sv
// Shared types and constants for the GLB port arbiter slice.
package glb_arb_pkg;

  localparam int GLB_ADDR_W = 32;
  localparam int GLB_DATA_W = 32;
  localparam int GLB_RD_LAT = 1;
  // Tag pipe covers the command stage plus the GLB read latency.
  localparam int unsigned RSP_PIPE_D = GLB_RD_LAT + 1;

  typedef enum logic {REQ_HOST = 1'b0, REQ_CTRL = 1'b1} req_id_e;

  typedef struct packed {
    logic [3:0]            we;
    logic [GLB_ADDR_W-1:0] addr;
    logic [GLB_DATA_W-1:0] wdata;
  } glb_cmd_t;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

endpackage

// File: rtl/glb_rsp_router.sv
// Tracks issued GLB reads through a {valid,id} tag pipe and steers returning
// read data to the requester that issued it.
module glb_rsp_router import glb_arb_pkg::*; #(
  parameter int DATA_W = GLB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  req_id_e           iss_id,
  input  logic [DATA_W-1:0] glb_r_data,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rsp_data,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_data
);

  rsp_tag_t pipe_q [RSP_PIPE_D];
  rsp_tag_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSP_PIPE_D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: iss_valid, id: iss_id};
      for (int unsigned i = 1; i < RSP_PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[RSP_PIPE_D-1];

  // Data is gated so idle and reset cycles present zero on both response buses.
  always_comb begin
    h_rsp_valid = tail.valid && (tail.id == REQ_HOST);
    c_rsp_valid = tail.valid && (tail.id == REQ_CTRL);
    h_rsp_data  = h_rsp_valid ? glb_r_data : '0;
    c_rsp_data  = c_rsp_valid ? glb_r_data : '0;
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// Round-robin arbiter sharing the GLB port between host (req 0) and controller (req 1).
// Optional stall counters are built when GLB_ARB_PERF_EN is defined.
module glb_port_arbiter import glb_arb_pkg::*; #(
  parameter int ADDR_W = GLB_ADDR_W,
  parameter int DATA_W = GLB_DATA_W,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_lock,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic [3:0]        h_req_we,
  input  logic [ADDR_W-1:0] h_req_addr,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rsp_data,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic [3:0]        c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_data,
  output logic [3:0]        glb_we,
  output logic [ADDR_W-1:0] glb_w_addr,
  output logic [DATA_W-1:0] glb_w_data,
  output logic              glb_re,
  output logic [ADDR_W-1:0] glb_r_addr,
  input  logic [DATA_W-1:0] glb_r_data,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_stall_h,
  output logic [PERF_W-1:0] perf_stall_c
);

  req_id_e  last_grant;
  req_id_e  acc_id;
  logic     accept;
  logic     acc_rd;
  glb_cmd_t acc_cmd;
  glb_cmd_t wr_q;

  always_comb begin
    h_req_ready = 1'b0;
    c_req_ready = 1'b0;
    if (ctrl_lock) begin
      c_req_ready = c_req_valid;
    end else if (h_req_valid && c_req_valid) begin
      if (last_grant == REQ_CTRL) h_req_ready = 1'b1;
      else                        c_req_ready = 1'b1;
    end else begin
      h_req_ready = h_req_valid;
      c_req_ready = c_req_valid;
    end
  end

  assign accept  = h_req_ready | c_req_ready;
  assign acc_id  = c_req_ready ? REQ_CTRL : REQ_HOST;
  assign acc_cmd = c_req_ready ? '{we: c_req_we, addr: c_req_addr, wdata: c_req_wdata}
                               : '{we: h_req_we, addr: h_req_addr, wdata: h_req_wdata};
  assign acc_rd  = accept && (acc_cmd.we == 4'h0);

  // Write fields hold between commands; only the enables return to zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_CTRL;
      wr_q       <= '0;
      glb_re     <= 1'b0;
      glb_r_addr <= '0;
    end else begin
      wr_q.we <= 4'h0;
      glb_re  <= 1'b0;
      if (accept) begin
        last_grant <= acc_id;
        if (acc_rd) begin
          glb_re     <= 1'b1;
          glb_r_addr <= acc_cmd.addr;
        end else begin
          wr_q <= acc_cmd;
        end
      end
    end
  end

  assign glb_we     = wr_q.we;
  assign glb_w_addr = wr_q.addr;
  assign glb_w_data = wr_q.wdata;

  glb_rsp_router #(
    .DATA_W (DATA_W)
  ) u_rsp_router (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (acc_rd),
    .iss_id      (acc_id),
    .glb_r_data  (glb_r_data),
    .h_rsp_valid (h_rsp_valid),
    .h_rsp_data  (h_rsp_data),
    .c_rsp_valid (c_rsp_valid),
    .c_rsp_data  (c_rsp_data)
  );

`ifdef GLB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_h <= '0;
      perf_stall_c <= '0;
    end else if (perf_clr) begin
      perf_stall_h <= '0;
      perf_stall_c <= '0;
    end else begin
      if (h_req_valid && !h_req_ready && (perf_stall_h != '1))
        perf_stall_h <= perf_stall_h + PERF_W'(1);
      if (c_req_valid && !c_req_ready && (perf_stall_c != '1))
        perf_stall_c <= perf_stall_c + PERF_W'(1);
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall_h    = '0;
  assign perf_stall_c    = '0;
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed self-checking bench for glb_port_arbiter with a behavioural GLB memory.
module tb_glb_port_arbiter;

  logic        clk, rst_n, ctrl_lock, perf_clr;
  logic        h_req_valid, h_req_ready, h_rsp_valid;
  logic [3:0]  h_req_we;
  logic [31:0] h_req_addr, h_req_wdata, h_rsp_data;
  logic        c_req_valid, c_req_ready, c_rsp_valid;
  logic [3:0]  c_req_we;
  logic [31:0] c_req_addr, c_req_wdata, c_rsp_data;
  logic [3:0]  glb_we;
  logic [31:0] glb_w_addr, glb_w_data, glb_r_addr;
  logic        glb_re;
  logic [31:0] glb_r_data = '0;
  logic [31:0] perf_stall_h, perf_stall_c;

  int checks = 0;
  int errors = 0;

  glb_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_lock(ctrl_lock),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
    .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
    .h_rsp_valid(h_rsp_valid), .h_rsp_data(h_rsp_data),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .perf_clr(perf_clr), .perf_stall_h(perf_stall_h), .perf_stall_c(perf_stall_c)
  );

  always #5 clk = ~clk;

  // GLB model: 256 words; unwritten words read back as 0xA0000000 | word index.
  logic [31:0] mem [256];
  bit          mem_wr [256];

  function automatic logic [31:0] mem_word(input logic [7:0] idx);
    return mem_wr[idx] ? mem[idx] : (32'hA000_0000 | {24'h0, idx});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (glb_we != 4'h0) begin
      mem[glb_w_addr[9:2]]    <= merge(mem_word(glb_w_addr[9:2]), glb_we, glb_w_data);
      mem_wr[glb_w_addr[9:2]] <= 1'b1;
    end
    if (glb_re) glb_r_data <= mem_word(glb_r_addr[9:2]);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input bit is_c, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wd);
    if (is_c) begin
      c_req_valid = 1'b1; c_req_we = we; c_req_addr = addr; c_req_wdata = wd;
    end else begin
      h_req_valid = 1'b1; h_req_we = we; h_req_addr = addr; h_req_wdata = wd;
    end
    #1;
    checks++;
    if ({h_req_ready, c_req_ready} !== (is_c ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL xfer_ready: got h/c=%b expected %b", {h_req_ready, c_req_ready},
               is_c ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1;
    h_req_valid = 1'b0;
    c_req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({glb_we, glb_w_addr, glb_w_data, glb_re, glb_r_addr, h_rsp_valid, h_rsp_data,
         c_rsp_valid, c_rsp_data, h_req_ready, c_req_ready, perf_stall_h, perf_stall_c} !== '0) begin
      errors++;
      $display("FAIL %s: outputs got we=%h wa=%h wd=%h re=%b ra=%h hv=%b hd=%h cv=%b cd=%h rdy=%b%b ph=%h pc=%h expected all 0",
               name, glb_we, glb_w_addr, glb_w_data, glb_re, glb_r_addr, h_rsp_valid, h_rsp_data,
               c_rsp_valid, c_rsp_data, h_req_ready, c_req_ready, perf_stall_h, perf_stall_c);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_write_read();
    xfer(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    checks++;
    if ({glb_we, glb_w_addr, glb_w_data, glb_re} !== {4'hF, 32'h10, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wr_cmd: got we=%h a=%h d=%h re=%b expected we=f a=10 d=deadbeef re=0",
               glb_we, glb_w_addr, glb_w_data, glb_re);
    end
    xfer(1'b0, 4'h0, 32'h10, 32'h0);
    checks++;
    if ({glb_re, glb_r_addr, glb_we, glb_w_addr, h_rsp_valid} !== {1'b1, 32'h10, 4'h0, 32'h10, 1'b0}) begin
      errors++;
      $display("FAIL rd_cmd: got re=%b ra=%h we=%h wa=%h hv=%b expected re=1 ra=10 we=0 wa=10 hv=0",
               glb_re, glb_r_addr, glb_we, glb_w_addr, h_rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({h_rsp_valid, c_rsp_valid, h_rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rd_rsp: got hv=%b cv=%b hd=%h expected hv=1 cv=0 hd=deadbeef",
               h_rsp_valid, c_rsp_valid, h_rsp_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({h_rsp_valid, c_rsp_valid, glb_re} !== 3'b000) begin
      errors++;
      $display("FAIL rd_idle: got hv=%b cv=%b re=%b expected 000", h_rsp_valid, c_rsp_valid, glb_re);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy, exp_v;
    logic [31:0] exp_d, got_d;
    int j;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        h_req_valid = 1'b1; h_req_we = 4'h0; h_req_addr = 32'h200 + 32'(4*i);
        c_req_valid = 1'b1; c_req_we = 4'h0; c_req_addr = 32'h300 + 32'(4*i);
      end else begin
        h_req_valid = 1'b0; c_req_valid = 1'b0;
      end
      #1;
      if (i < 6) begin
        exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
        checks++;
        if ({h_req_ready, c_req_ready} !== exp_rdy) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got h/c=%b expected %b", i, {h_req_ready, c_req_ready}, exp_rdy);
        end
      end
      if (i >= 2) begin
        j = i - 2;
        exp_v = (j % 2 == 0) ? 2'b10 : 2'b01;
        exp_d = (j % 2 == 0) ? 32'hA000_0080 + 32'(j) : 32'hA000_00C0 + 32'(j);
        got_d = (j % 2 == 0) ? h_rsp_data : c_rsp_data;
        checks++;
        if ({h_rsp_valid, c_rsp_valid} !== exp_v || got_d !== exp_d) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", j,
                   {h_rsp_valid, c_rsp_valid}, got_d, exp_v, exp_d);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ctrl_lock();
    logic [1:0]  exp_v;
    logic [31:0] exp_d, got_d;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        ctrl_lock = 1'b1;
        h_req_valid = 1'b1; h_req_we = 4'h0; h_req_addr = 32'h50;
        c_req_valid = 1'b1; c_req_we = 4'h0; c_req_addr = 32'h20;
      end else if (i == 10) begin
        ctrl_lock = 1'b0; c_req_valid = 1'b0; h_req_valid = 1'b1;
      end else begin
        h_req_valid = 1'b0; c_req_valid = 1'b0;
      end
      #1;
      if (i <= 10) begin
        checks++;
        if ({h_req_ready, c_req_ready} !== ((i < 10) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL lock_ready[%0d]: got h/c=%b expected %b", i, {h_req_ready, c_req_ready},
                   (i < 10) ? 2'b01 : 2'b10);
        end
      end
      exp_v = (i >= 2 && i < 12) ? 2'b01 : (i == 12) ? 2'b10 : 2'b00;
      exp_d = (i == 12) ? 32'hA000_0014 : (exp_v == 2'b01) ? 32'hA000_0008 : 32'h0;
      got_d = (i == 12) ? h_rsp_data : c_rsp_data;
      checks++;
      if ({h_rsp_valid, c_rsp_valid} !== exp_v || got_d !== exp_d) begin
        errors++;
        $display("FAIL lock_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", i,
                 {h_rsp_valid, c_rsp_valid}, got_d, exp_v, exp_d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_partial_write();
    xfer(1'b1, 4'hF, 32'h40, 32'h11223344);
    xfer(1'b0, 4'b0011, 32'h40, 32'h0000ABCD);
    checks++;
    if ({glb_we, glb_w_addr, glb_w_data} !== {4'b0011, 32'h40, 32'h0000ABCD}) begin
      errors++;
      $display("FAIL pw_cmd: got we=%h a=%h d=%h expected we=3 a=40 d=0000abcd",
               glb_we, glb_w_addr, glb_w_data);
    end
    xfer(1'b1, 4'h0, 32'h40, 32'h0);
    @(posedge clk); #1;
    checks++;
    if ({h_rsp_valid, c_rsp_valid, c_rsp_data} !== {2'b01, 32'h1122ABCD}) begin
      errors++;
      $display("FAIL pw_rsp: got hv=%b cv=%b cd=%h expected hv=0 cv=1 cd=1122abcd",
               h_rsp_valid, c_rsp_valid, c_rsp_data);
    end
  endtask

  task automatic test_reset_midop();
    xfer(1'b1, 4'h0, 32'h200, 32'h0);
    xfer(1'b0, 4'h0, 32'h204, 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset_now");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all_zero("midop_in_reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({h_rsp_valid, c_rsp_valid, glb_re} !== 3'b000) begin
        errors++;
        $display("FAIL midop_no_rsp[%0d]: got hv=%b cv=%b re=%b expected 000", i,
                 h_rsp_valid, c_rsp_valid, glb_re);
      end
    end
    h_req_valid = 1'b1; h_req_we = 4'h0; h_req_addr = 32'h0;
    c_req_valid = 1'b1; c_req_we = 4'h0; c_req_addr = 32'h4;
    #1;
    checks++;
    if ({h_req_ready, c_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_grant: got h/c=%b expected 10", {h_req_ready, c_req_ready});
    end
    h_req_valid = 1'b0; c_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_perf();
    logic [31:0] exp5;
`ifdef GLB_ARB_PERF_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    ctrl_lock = 1'b1; perf_clr = 1'b1;
    h_req_valid = 1'b1; h_req_we = 4'h0; h_req_addr = 32'h0;
    @(posedge clk); #1;
    checks++;
    if ({perf_stall_h, perf_stall_c} !== 64'h0) begin
      errors++;
      $display("FAIL perf_clr_wins: got h=%0d c=%0d expected 0 0", perf_stall_h, perf_stall_c);
    end
    perf_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    h_req_valid = 1'b0;
    checks++;
    if ({perf_stall_h, perf_stall_c} !== {exp5, 32'h0}) begin
      errors++;
      $display("FAIL perf_count: got h=%0d c=%0d expected %0d 0", perf_stall_h, perf_stall_c, exp5);
    end
    @(posedge clk); #1;
    checks++;
    if (perf_stall_h !== exp5) begin
      errors++;
      $display("FAIL perf_hold: got h=%0d expected %0d", perf_stall_h, exp5);
    end
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    ctrl_lock = 1'b0;
    checks++;
    if ({perf_stall_h, perf_stall_c} !== 64'h0) begin
      errors++;
      $display("FAIL perf_clear: got h=%0d c=%0d expected 0 0", perf_stall_h, perf_stall_c);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; ctrl_lock = 1'b0; perf_clr = 1'b0;
    h_req_valid = 1'b0; h_req_we = 4'h0; h_req_addr = '0; h_req_wdata = '0;
    c_req_valid = 1'b0; c_req_we = 4'h0; c_req_addr = '0; c_req_wdata = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ctrl_lock();
    test_partial_write();
    test_reset_midop();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
